// File: rtl/associate_wide.sv
// associate_wide: N-input saturating fixed-point neuron with one shared multiplier and delta-rule learning.
// Define ASSOCIATE_WIDE_LFSR_INIT_EN to load small pseudo-random weights from an LFSR after reset.
module associate_wide #(
    parameter int N          = 2,
    parameter int AW         = 8,
    parameter int WW         = 16,
    parameter int FRAC       = 8,
    parameter int RATE       = 2,
    parameter int SIGNED_ARG = 0,
    parameter int SEED       = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               arg_stb,
    input  logic [AW*N-1:0]    arg_dat,
    output logic               arg_rdy,
    output logic               res_stb,
    output logic [WW-1:0]      res_dat,
    input  logic               res_rdy,
    input  logic               err_stb,
    input  logic [WW-1:0]      err_dat,
    output logic               err_rdy,
    output logic               fbk_stb,
    output logic [WW*N-1:0]    fbk_dat,
    input  logic               fbk_rdy,
    output logic               busy
);

    // SW holds any product or sum without wrapping, so saturation sees the true value
    localparam int SW = 2*WW + AW + 2;
    localparam int CW = $clog2(N+1);
    localparam logic signed [SW-1:0] SMAX = {{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN = ~SMAX;

`ifdef ASSOCIATE_WIDE_LFSR_INIT_EN
    typedef enum logic [2:0] {ARG, MAC, RES, DEL, ERR, FBK, UPD, INIT} state_t;
`else
    typedef enum logic [2:0] {ARG, MAC, RES, DEL, ERR, FBK, UPD} state_t;
`endif

    function automatic logic signed [WW-1:0] sat(input logic signed [SW-1:0] x);
        if (x > SMAX)
            return SMAX[WW-1:0];
        else if (x < SMIN)
            return SMIN[WW-1:0];
        else
            return x[WW-1:0];
    endfunction

    function automatic logic signed [AW:0] ext_arg(input logic [AW-1:0] x);
        if (SIGNED_ARG != 0)
            return {x[AW-1], x};
        else
            return {1'b0, x};
    endfunction

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic signed [WW-1:0]   w [N];
    logic signed [AW:0]     a [N];
    logic signed [WW-1:0]   fbk [N];
    logic signed [WW-1:0]   bias;
    logic signed [WW-1:0]   delta;
    logic signed [WW-1:0]   acc;
    logic signed [SW-1:0]   mul;

    logic signed [WW-1:0]   w_cur;
    logic signed [AW:0]     a_cur;
    logic signed [SW-1:0]   op_x;
    logic signed [SW-1:0]   op_y;
    logic signed [SW-1:0]   prod;

    // The single multiplier serves w*a in MAC, w*delta in ERR and delta*a in UPD
    always_comb begin
        w_cur = '0;
        a_cur = '0;
        for (int i = 0; i < N; i++) begin
            if (cnt == CW'(i)) begin
                w_cur = w[i];
                a_cur = a[i];
            end
        end
        op_x = (state == UPD) ? SW'(delta) : SW'(w_cur);
        op_y = (state == ERR) ? SW'(delta) : SW'(a_cur);
        prod = op_x * op_y;
    end

`ifdef ASSOCIATE_WIDE_LFSR_INIT_EN
    localparam int ISH = WW - FRAC + 2;

    function automatic logic [63:0] lfsr_taps(input int width);
        case (width)
            4:       return 64'hC;
            8:       return 64'hB8;
            12:      return 64'hE08;
            16:      return 64'hB400;
            20:      return 64'h90000;
            24:      return 64'hE10000;
            32:      return 64'hA3000000;
            default: return 64'h3 << (width - 2);
        endcase
    endfunction

    localparam logic [WW-1:0] TAPS = WW'(lfsr_taps(WW));

    logic [WW-1:0] lfsr;
    logic [WW-1:0] lfsr_next;
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef ASSOCIATE_WIDE_LFSR_INIT_EN
            state <= INIT;
            lfsr  <= WW'(SEED);
`else
            state <= ARG;
`endif
            cnt     <= '0;
            res_stb <= 1'b0;
            fbk_stb <= 1'b0;
            res_dat <= '0;
            bias    <= '0;
            delta   <= '0;
            acc     <= '0;
            mul     <= '0;
            for (int i = 0; i < N; i++) begin
                w[i]   <= '0;
                a[i]   <= '0;
                fbk[i] <= '0;
            end
        end else begin
            case (state)
                ARG: begin
                    if (arg_stb) begin
                        for (int i = 0; i < N; i++)
                            a[i] <= ext_arg(arg_dat[AW*i +: AW]);
                        acc   <= bias;
                        cnt   <= '0;
                        state <= MAC;
                    end
                end
                // Product of step c is accumulated in step c+1, hence N+1 steps
                MAC: begin
                    if (cnt != CW'(N))
                        mul <= prod >>> AW;
                    if (cnt != '0)
                        acc <= sat(SW'(acc) + mul);
                    if (cnt == CW'(N)) begin
                        cnt   <= '0;
                        state <= RES;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RES: begin
                    if (!res_stb) begin
                        res_stb <= 1'b1;
                        res_dat <= acc;
                    end else if (res_rdy) begin
                        res_stb <= 1'b0;
                        state   <= en ? DEL : ARG;
                    end
                end
                DEL: begin
                    if (err_stb) begin
                        delta <= err_dat;
                        cnt   <= '0;
                        state <= ERR;
                    end
                end
                ERR: begin
                    for (int i = 0; i < N; i++)
                        if (cnt == CW'(i))
                            fbk[i] <= sat(prod >>> FRAC);
                    if (cnt == CW'(N-1)) begin
                        cnt   <= '0;
                        state <= FBK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                FBK: begin
                    if (!fbk_stb) begin
                        fbk_stb <= 1'b1;
                    end else if (fbk_rdy) begin
                        fbk_stb <= 1'b0;
                        cnt     <= '0;
                        state   <= UPD;
                    end
                end
                UPD: begin
                    for (int i = 0; i < N; i++)
                        if (cnt == CW'(i))
                            w[i] <= sat(SW'(w_cur) + (prod >>> (AW + RATE)));
                    if (cnt == '0)
                        bias <= sat(SW'(bias) + (SW'(delta) >>> RATE));
                    if (cnt == CW'(N-1)) begin
                        cnt   <= '0;
                        state <= ARG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef ASSOCIATE_WIDE_LFSR_INIT_EN
                INIT: begin
                    for (int i = 0; i < N; i++)
                        if (cnt == CW'(i))
                            w[i] <= $signed(lfsr) >>> ISH;
                    lfsr <= lfsr_next;
                    if (cnt == CW'(N-1)) begin
                        cnt   <= '0;
                        state <= ARG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                default: state <= state_t'('x);
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (SEED != 0) else $fatal(1, "associate_wide: SEED must be nonzero");
`ifndef ASSOCIATE_WIDE_LFSR_INIT_EN
            assert (state inside {ARG, MAC, RES, DEL, ERR, FBK, UPD})
                else $fatal(1, "associate_wide: illegal state encoding");
`endif
        end
    end

    assign arg_rdy = (state == ARG);
    assign err_rdy = (state == DEL);
    assign busy    = (state != ARG);

    for (genvar i = 0; i < N; i++) begin : g_fbk
        assign fbk_dat[WW*i +: WW] = fbk[i];
    end

endmodule

// File: tb/tb_associate_wide.sv
// Directed bench for associate_wide: forward pass, learning, saturation, backpressure, reset and signed args.
// Two instances (unsigned and signed args) share stimulus and run in lockstep since timing is data-independent.
module tb_associate_wide;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int WW = 16;

    logic clk = 1'b0;
    logic rst, en, arg_stb, res_rdy, err_stb, fbk_rdy;
    logic [AW*N-1:0] arg_dat;
    logic [WW-1:0]   err_dat;

    logic            arg_rdy, res_stb, err_rdy, fbk_stb, busy;
    logic [WW-1:0]   res_dat;
    logic [WW*N-1:0] fbk_dat;

    logic            s_arg_rdy, s_res_stb, s_err_rdy, s_fbk_stb, s_busy;
    logic [WW-1:0]   s_res_dat;
    logic [WW*N-1:0] s_fbk_dat;

    int   tests = 0;
    int   fails = 0;
    int   err_seen = 0;
    logic watch_err = 1'b0;
    logic use_signed = 1'b0;

    associate_wide u_dut (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
        .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
        .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy),
        .busy(busy)
    );

    associate_wide #(.SIGNED_ARG(1)) u_signed (
        .clk(clk), .rst(rst), .en(en),
        .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(s_arg_rdy),
        .res_stb(s_res_stb), .res_dat(s_res_dat), .res_rdy(res_rdy),
        .err_stb(err_stb), .err_dat(err_dat), .err_rdy(s_err_rdy),
        .fbk_stb(s_fbk_stb), .fbk_dat(s_fbk_dat), .fbk_rdy(fbk_rdy),
        .busy(s_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (watch_err && err_rdy)
            err_seen <= err_seen + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return arg_rdy;
            1:       return res_stb;
            2:       return err_rdy;
            default: return fbk_stb;
        endcase
    endfunction

    task automatic waitSignal(input int sel, input string tag, output int cycles);
        cycles = 0;
        while (!pick(sel) && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!pick(sel))
            checkOutput({tag, "_timeout"}, 32'(pick(sel)), 32'd1);
    endtask

    task automatic doReset();
        rst = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic sendArgs(input logic [7:0] a0, input logic [7:0] a1, output int lat);
        int c;
        waitSignal(0, "arg_rdy", c);
        arg_dat = {a1, a0};
        arg_stb = 1'b1;
        @(posedge clk); #1;
        arg_stb = 1'b0;
        waitSignal(1, "res_stb", lat);
    endtask

    task automatic takeResult();
        res_rdy = 1'b1;
        @(posedge clk); #1;
        res_rdy = 1'b0;
    endtask

    task automatic sendErr(input logic [WW-1:0] d);
        int c;
        waitSignal(2, "err_rdy", c);
        err_dat = d;
        err_stb = 1'b1;
        @(posedge clk); #1;
        err_stb = 1'b0;
        waitSignal(3, "fbk_stb", c);
    endtask

    task automatic takeFbk();
        fbk_rdy = 1'b1;
        @(posedge clk); #1;
        fbk_rdy = 1'b0;
    endtask

    task automatic forward(input logic [7:0] a0, input logic [7:0] a1,
                           input logic [WW-1:0] exp, input string tag);
        int lat;
        en = 1'b0;
        sendArgs(a0, a1, lat);
        checkOutput(tag, 32'(use_signed ? s_res_dat : res_dat), 32'(exp));
        takeResult();
    endtask

    // One full learning transaction: forward, delta, feedback, weight update
    task automatic applyStimulus(input logic [7:0] a0, input logic [7:0] a1, input logic [WW-1:0] d,
                                 input logic [WW-1:0] exp_res, input logic [31:0] exp_fbk,
                                 input string tag);
        int lat, c;
        en = 1'b1;
        sendArgs(a0, a1, lat);
        checkOutput({tag, "_res"}, 32'(use_signed ? s_res_dat : res_dat), 32'(exp_res));
        takeResult();
        en = 1'b0;
        sendErr(d);
        checkOutput({tag, "_fbk"}, use_signed ? s_fbk_dat : fbk_dat, exp_fbk);
        takeFbk();
        waitSignal(0, {tag, "_idle"}, c);
    endtask

    logic [WW-1:0] pos_res [6] = '{16'h0000, 16'h5F7D, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    logic [WW-1:0] neg_res [6] = '{16'h0000, 16'hA07E, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
    logic [31:0]   sat_fbk [6] = '{32'h0, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFF7FFF};

    initial begin
        int            lat;
        int            bad;
        logic [WW-1:0] d;
        logic [31:0]   f;

        rst = 1'b1; en = 1'b0; arg_stb = 1'b0; arg_dat = '0; res_rdy = 1'b0;
        err_stb = 1'b0; err_dat = '0; fbk_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_arg_rdy", 32'(arg_rdy), 32'd1);
        checkOutput("rst_busy",    32'(busy),    32'd0);
        checkOutput("rst_res_stb", 32'(res_stb), 32'd0);
        checkOutput("rst_fbk_stb", 32'(fbk_stb), 32'd0);
        checkOutput("rst_err_rdy", 32'(err_rdy), 32'd0);
        checkOutput("rst_res_dat", 32'(res_dat), 32'd0);
        checkOutput("rst_fbk_dat", fbk_dat,      32'd0);

        // Zero-weight forward with learning disabled
        watch_err = 1'b1;
        en = 1'b0;
        sendArgs(8'h80, 8'hFF, lat);
        checkOutput("s1_latency", 32'(lat), 32'd4);
        checkOutput("s1_res", 32'(res_dat), 32'h0000);
        takeResult();
        checkOutput("s1_arg_rdy_after", 32'(arg_rdy), 32'd1);
        checkOutput("s1_res_stb_drop",  32'(res_stb), 32'd0);
        repeat (4) @(posedge clk);
        #1 watch_err = 1'b0;
        checkOutput("s1_err_rdy_never", 32'(err_seen), 32'd0);

        // Learning step and retrained forward
        applyStimulus(8'h80, 8'h40, 16'h0100, 16'h0000, 32'h0000_0000, "s2_learn");
        forward(8'h80, 8'h40, 16'h0054, "s2_fwd");

        // Backpressure on result then feedback channel
        en = 1'b1;
        sendArgs(8'h80, 8'h40, lat);
        d = res_dat;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (res_stb !== 1'b1 || res_dat !== d || arg_rdy !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        checkOutput("s4_res_hold", 32'(bad), 32'd0);
        checkOutput("s4_res_dat",  32'(d),   32'h0054);
        takeResult();
        en = 1'b0;
        sendErr(16'h0100);
        f = fbk_dat;
        bad = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (fbk_stb !== 1'b1 || fbk_dat !== f || arg_rdy !== 1'b0 || busy !== 1'b1)
                bad++;
        end
        checkOutput("s4_fbk_hold", 32'(bad), 32'd0);
        checkOutput("s4_fbk_dat",  f,        32'h0010_0020);
        takeFbk();

        // Reset during the second UPD cycle clears the trained state
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("s5_res_stb", 32'(res_stb), 32'd0);
        checkOutput("s5_fbk_stb", 32'(fbk_stb), 32'd0);
        checkOutput("s5_arg_rdy", 32'(arg_rdy), 32'd1);
        rst = 1'b0;
        forward(8'h80, 8'h40, 16'h0000, "s5_fwd_after_rst");

        // Reset with a result strobe pending drops it
        sendArgs(8'hFF, 8'hFF, lat);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("s5_pending_drop", 32'(res_stb), 32'd0);
        checkOutput("s5_pending_rdy",  32'(arg_rdy), 32'd1);
        rst = 1'b0;

        // Positive saturation of bias, weights and result
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(8'hFF, 8'hFF, 16'h7FFF, pos_res[i], sat_fbk[i], $sformatf("s3_pos%0d", i));
        forward(8'h00, 8'h00, 16'h7FFC, "s3_bias4");
        for (int i = 4; i < 6; i++)
            applyStimulus(8'hFF, 8'hFF, 16'h7FFF, pos_res[i], sat_fbk[i], $sformatf("s3_pos%0d", i));
        forward(8'h00, 8'h00, 16'h7FFF, "s3_bias6");
        forward(8'hFF, 8'hFF, 16'h7FFF, "s3_fwd_pos");

        // Negative mirror
        doReset();
        for (int i = 0; i < 6; i++)
            applyStimulus(8'hFF, 8'hFF, 16'h8000, neg_res[i], sat_fbk[i], $sformatf("s3_neg%0d", i));
        forward(8'h00, 8'h00, 16'h8000, "s3_bias_neg");
        forward(8'hFF, 8'hFF, 16'h8000, "s3_fwd_neg");

        // Signed arguments: train w0=0x20, w1=0x10, bias=0x40 then apply a0=-0.5
        doReset();
        use_signed = 1'b1;
        applyStimulus(8'h40, 8'h20, 16'h0200, 16'h0000, 32'h0000_0000, "s6_learn_a");
        applyStimulus(8'h00, 8'h00, 16'hFF00, 16'h0080, 32'hFFF0_FFE0, "s6_learn_b");
        forward(8'h80, 8'h40, 16'h0034, "s6_fwd_signed");
        use_signed = 1'b0;
        forward(8'h80, 8'h40, 16'h0054, "s6_fwd_unsigned");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
